// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution operand sequencer.
// CONV_SEQ_RELU_EN selects ReLU clamping of the written accumulator.
package conv_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 1;

    localparam logic [2:0] ALU_OP_CONV = 3'b111;
    localparam logic [2:0] ALU_OP_NOP  = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        RD_K,
        RD_I,
        LATCH,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Value written to memory for a finished output pixel.
    function automatic logic [DATA_W-1:0] wr_value(input logic [DATA_W-1:0] acc);
`ifdef CONV_SEQ_RELU_EN
        return acc[DATA_W-1] ? '0 : acc;
`else
        return acc;
`endif
    endfunction

endpackage

// File: rtl/conv_seq_agen.sv
// Address generator: owns tap/output counters and the image pointer, and
// keeps rd_addr/wr_addr registered one step ahead of the sequencer.
module conv_seq_agen
    import conv_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              sel_img,
    input  logic              tap_adv,
    input  logic              out_adv,
    input  logic [ADDR_W-1:0] cfg_ker_base,
    input  logic [ADDR_W-1:0] cfg_img_base,
    input  logic [ADDR_W-1:0] cfg_img_stride,
    input  logic [ADDR_W-1:0] cfg_out_base,
    output logic [CNT_W-1:0]  tap_cnt,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);

    logic [ADDR_W-1:0] ker_base;
    logic [ADDR_W-1:0] img_stride;
    logic [ADDR_W-1:0] img_ptr;

    // rd_addr normally points at the next kernel word; it switches to the
    // image word only for the RD_I cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ker_base   <= '0;
            img_stride <= '0;
            img_ptr    <= '0;
            tap_cnt    <= '0;
            out_cnt    <= '0;
            rd_addr    <= '0;
            wr_addr    <= '0;
        end else if (load) begin
            ker_base   <= cfg_ker_base;
            img_stride <= cfg_img_stride;
            img_ptr    <= cfg_img_base;
            tap_cnt    <= '0;
            out_cnt    <= '0;
            rd_addr    <= cfg_ker_base;
            wr_addr    <= cfg_out_base;
        end else if (tap_adv) begin
            tap_cnt <= tap_cnt + CNT_W'(1);
            rd_addr <= ker_base + ADDR_W'(tap_cnt) + ADDR_W'(1);
        end else if (out_adv) begin
            out_cnt <= out_cnt + CNT_W'(1);
            img_ptr <= img_ptr + img_stride;
            tap_cnt <= '0;
            rd_addr <= ker_base;
            wr_addr <= wr_addr + ADDR_W'(1);
        end else if (sel_img) begin
            rd_addr <= img_ptr + ADDR_W'(tap_cnt);
        end
    end

endmodule

// File: rtl/conv_operand_sequencer.sv
// CNN-offload sequencer: fetches kernel/image words, drives the ALU conv op,
// accumulates per output pixel and writes results back. Macro: CONV_SEQ_RELU_EN.
module conv_operand_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_ker_base,
    input  logic [ADDR_W-1:0] cfg_img_base,
    input  logic [ADDR_W-1:0] cfg_img_stride,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [CNT_W-1:0]  cfg_taps,
    input  logic [CNT_W-1:0]  cfg_num_out,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [31:0]       alu_result,
    output logic              busy,
    output logic              done,
    output logic              acc_ovf
);

    state_t             state;
    logic [31:0]        acc;
    logic [CNT_W-1:0]   taps_q;
    logic [CNT_W-1:0]   num_out_q;
    logic [CNT_W-1:0]   tap_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [RD_LAT-1:0]  rd_pend;

    logic        load_c;
    logic        sel_img_c;
    logic        tap_adv_c;
    logic        out_adv_c;
    logic [31:0] sum_c;
    logic        ovf_c;

    assign load_c    = (state == IDLE) && start;
    assign sel_img_c = (state == RD_K);
    assign tap_adv_c = (state == MAC);
    assign out_adv_c = (state == WRITE) && wr_ready;

    assign sum_c = acc + alu_result;
    assign ovf_c = (acc[31] == alu_result[31]) && (sum_c[31] != acc[31]);

    conv_seq_agen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_agen (
        .clk            (clk),
        .rst            (rst),
        .load           (load_c),
        .sel_img        (sel_img_c),
        .tap_adv        (tap_adv_c),
        .out_adv        (out_adv_c),
        .cfg_ker_base   (cfg_ker_base),
        .cfg_img_base   (cfg_img_base),
        .cfg_img_stride (cfg_img_stride),
        .cfg_out_base   (cfg_out_base),
        .tap_cnt        (tap_cnt),
        .out_cnt        (out_cnt),
        .rd_addr        (rd_addr),
        .wr_addr        (wr_addr)
    );

    // Sequencer FSM, accumulator and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= ALU_OP_NOP;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc_ovf   <= 1'b0;
            acc       <= '0;
            taps_q    <= '0;
            num_out_q <= '0;
            rd_pend   <= '0;
        end else begin
            rd_pend <= RD_LAT'({rd_pend, rd_en});
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        taps_q    <= cfg_taps;
                        num_out_q <= cfg_num_out;
                        acc       <= '0;
                        acc_ovf   <= 1'b0;
                        if (cfg_num_out == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                            if (cfg_taps == '0) begin
                                state   <= WRITE;
                                wr_en   <= 1'b1;
                                wr_data <= wr_value('0);
                            end else begin
                                state <= RD_K;
                                rd_en <= 1'b1;
                            end
                        end
                    end
                end
                RD_K: state <= RD_I;
                RD_I: begin
                    if (rd_pend[RD_LAT-1]) alu_b <= rd_data;
                    rd_en <= 1'b0;
                    state <= LATCH;
                end
                LATCH: begin
                    if (rd_pend[RD_LAT-1]) alu_a <= rd_data;
                    alu_ctrl <= ALU_OP_CONV;
                    state    <= MAC;
                end
                MAC: begin
                    acc      <= sum_c;
                    acc_ovf  <= acc_ovf | ovf_c;
                    alu_ctrl <= ALU_OP_NOP;
                    if (tap_cnt + CNT_W'(1) == taps_q) begin
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        wr_data <= wr_value(sum_c);
                    end else begin
                        state <= RD_K;
                        rd_en <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        acc <= '0;
                        if (out_cnt + CNT_W'(1) == num_out_q) begin
                            state <= DONE;
                            wr_en <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (taps_q == '0) begin
                            wr_data <= wr_value('0);
                        end else begin
                            state <= RD_K;
                            wr_en <= 1'b0;
                            rd_en <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_operand_sequencer.sv
// Directed bench for conv_operand_sequencer with memory and adder-ALU models.
module tb_conv_operand_sequencer;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] cfg_ker_base, cfg_img_base, cfg_img_stride, cfg_out_base;
    logic [CNT_W-1:0]  cfg_taps, cfg_num_out;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready;
    logic [31:0]       alu_a, alu_b, alu_result;
    logic [2:0]        alu_ctrl;
    logic              busy, done, acc_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_operand_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_ker_base   (cfg_ker_base),
        .cfg_img_base   (cfg_img_base),
        .cfg_img_stride (cfg_img_stride),
        .cfg_out_base   (cfg_out_base),
        .cfg_taps       (cfg_taps),
        .cfg_num_out    (cfg_num_out),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_ctrl       (alu_ctrl),
        .alu_result     (alu_result),
        .busy           (busy),
        .done           (done),
        .acc_ovf        (acc_ovf)
    );

    // Memory with one-cycle read latency; the ALU model simply adds A and B.
    logic [31:0] mem [0:1023];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
    assign alu_result = (alu_ctrl == 3'b111) ? alu_a + alu_b : 32'h0;

    // Bus monitor, sampled mid-cycle.
    int          cyc = 0;
    int          done_cnt, mac_cnt, wr_en_cnt;
    int          start_cyc, first_wr_cyc, last_acc_cyc, last_done_cyc;
    int unsigned rd_log[$];
    int unsigned wa_log[$];
    logic [31:0] wd_log[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (start && !busy && start_cyc < 0) start_cyc = cyc;
            if (rd_en) rd_log.push_back(32'(rd_addr));
            if (wr_en) begin
                wr_en_cnt++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (wr_ready) begin
                    wa_log.push_back(32'(wr_addr));
                    wd_log.push_back(wr_data);
                    last_acc_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (alu_ctrl == 3'b111) mac_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
        done_cnt = 0; mac_cnt = 0; wr_en_cnt = 0;
        start_cyc = -1; first_wr_cyc = -1; last_acc_cyc = -1; last_done_cyc = -1;
    endtask

    // Pulse start, then scramble config so late changes would be visible.
    task automatic launch(input logic [9:0] kb, input logic [9:0] ib, input logic [9:0] is,
                          input logic [9:0] ob, input logic [7:0] taps, input logic [7:0] nout);
        clear_logs();
        cfg_ker_base = kb; cfg_img_base = ib; cfg_img_stride = is; cfg_out_base = ob;
        cfg_taps = taps; cfg_num_out = nout;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_ker_base = 10'h155; cfg_img_base = 10'h2AA; cfg_img_stride = 10'h033;
        cfg_out_base = 10'h1CC; cfg_taps = 8'h07; cfg_num_out = 8'h05;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s_timeout: done_cnt=%0d required 1 within %0d cycles", name, done_cnt, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, done, rd_en, wr_en, acc_ovf} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 00000", {busy, done, rd_en, wr_en, acc_ovf});
        end
        total++;
        if ({alu_ctrl, alu_a, alu_b} !== 67'h0) begin
            bad++;
            $display("FAIL reset_alu: ctrl=%h a=%h b=%h required all 0", alu_ctrl, alu_a, alu_b);
        end
        total++;
        if ({rd_addr, wr_addr, wr_data} !== 52'h0) begin
            bad++;
            $display("FAIL reset_bus: rd_addr=%h wr_addr=%h wr_data=%h required all 0", rd_addr, wr_addr, wr_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int unsigned exp_rd[4] = '{32'h100, 32'h200, 32'h101, 32'h201};
        bit ok;
        mem[10'h100] = 32'd4;  mem[10'h101] = 32'd5;
        mem[10'h200] = 32'd6;  mem[10'h201] = 32'd15;
        wr_ready = 1'b1;
        launch(10'h100, 10'h200, 10'h000, 10'h300, 8'd2, 8'd1);
        total++;
        if ({busy, rd_en, rd_addr} !== {1'b1, 1'b1, 10'h100}) begin
            bad++;
            $display("FAIL basic_first_read: busy=%b rd_en=%b rd_addr=%h required 1 1 100", busy, rd_en, rd_addr);
        end
        wait_done(60, "basic");
        total++;
        if (wa_log.size() != 1 || wa_log[0] != 32'h300 || wd_log[0] !== 32'd30) begin
            bad++;
            $display("FAIL basic_write: got %p / %p required one write of 30 to 300", wa_log, wd_log);
        end
        ok = (rd_log.size() == 4);
        for (int i = 0; i < 4 && ok; i++) ok = (rd_log[i] == exp_rd[i]);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_reads: got %p required %p", rd_log, exp_rd);
        end
        total++;
        if (first_wr_cyc - start_cyc != 9) begin
            bad++;
            $display("FAIL basic_tap_latency: first write %0d cycles after start, required 9", first_wr_cyc - start_cyc);
        end
        total++;
        if (last_done_cyc != last_acc_cyc + 1 || done_cnt != 1) begin
            bad++;
            $display("FAIL basic_done_timing: done at %0d (count %0d), required %0d (count 1)", last_done_cyc, done_cnt, last_acc_cyc + 1);
        end
        total++;
        if ({busy, acc_ovf} !== 2'b00 || mac_cnt != 2) begin
            bad++;
            $display("FAIL basic_end_state: busy=%b ovf=%b macs=%0d required 0 0 2", busy, acc_ovf, mac_cnt);
        end
    endtask

    task automatic test_stride();
        int unsigned exp_rd[6] = '{32'h40, 32'h10, 32'h40, 32'h14, 32'h40, 32'h18};
        bit ok;
        mem[10'h040] = 32'd2;
        mem[10'h010] = 32'd1; mem[10'h014] = 32'd3; mem[10'h018] = 32'd5;
        wr_ready = 1'b1;
        launch(10'h010 + 10'h030, 10'h010, 10'h004, 10'h080, 8'd1, 8'd3);
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100, "stride");
        ok = (rd_log.size() == 6);
        for (int i = 0; i < 6 && ok; i++) ok = (rd_log[i] == exp_rd[i]);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stride_reads: got %p required %p", rd_log, exp_rd);
        end
        total++;
        if (wa_log.size() != 3 || wa_log[0] != 32'h80 || wa_log[1] != 32'h81 || wa_log[2] != 32'h82) begin
            bad++;
            $display("FAIL stride_waddr: got %p required 80 81 82", wa_log);
        end
        total++;
        if (wd_log.size() != 3 || wd_log[0] !== 32'd3 || wd_log[1] !== 32'd5 || wd_log[2] !== 32'd7) begin
            bad++;
            $display("FAIL stride_wdata: got %p required 3 5 7", wd_log);
        end
        tick(); tick(); tick();
        total++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stride_ignore_start: done_cnt=%0d busy=%b required 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        mem[10'h050] = 32'd7; mem[10'h060] = 32'd8;
        wr_ready = 1'b0;
        launch(10'h050, 10'h060, 10'h000, 10'h090, 8'd1, 8'd1);
        while (!wr_en && n < 40) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'h090, 32'd15}) begin
                bad++;
                $display("FAIL bp_hold_%0d: en=%b addr=%h data=%0d required 1 090 15", i, wr_en, wr_addr, wr_data);
            end
        end
        tick();
        total++;
        if (wa_log.size() != 0) begin
            bad++;
            $display("FAIL bp_early_accept: %0d writes while stalled, required 0", wa_log.size());
        end
        wr_ready = 1'b1;
        wait_done(20, "bp");
        total++;
        if (wa_log.size() != 1 || wd_log[0] !== 32'd15 || last_acc_cyc - first_wr_cyc != 5) begin
            bad++;
            $display("FAIL bp_accept: writes=%0d data=%p accepted in cycle %0d of wr_en, required 1 15 6", wa_log.size(), wd_log, last_acc_cyc - first_wr_cyc + 1);
        end
    endtask

    task automatic test_zero();
        wr_ready = 1'b1;
        launch(10'h000, 10'h000, 10'h000, 10'h020, 8'd3, 8'd0);
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++;
            $display("FAIL zero_out_done: done=%b busy=%b required 1 0", done, busy);
        end
        tick(); tick(); tick();
        total++;
        if (done_cnt != 1 || rd_log.size() != 0 || wr_en_cnt != 0) begin
            bad++;
            $display("FAIL zero_out_quiet: done_cnt=%0d reads=%0d wr_cycles=%0d required 1 0 0", done_cnt, rd_log.size(), wr_en_cnt);
        end
        launch(10'h000, 10'h000, 10'h000, 10'h030, 8'd0, 8'd2);
        wait_done(20, "zero_taps");
        total++;
        if (wa_log.size() != 2 || wa_log[0] != 32'h30 || wa_log[1] != 32'h31 ||
            wd_log[0] !== 32'h0 || wd_log[1] !== 32'h0 || rd_log.size() != 0) begin
            bad++;
            $display("FAIL zero_taps_writes: addr %p data %p reads %0d required 30 31 / 0 0 / 0", wa_log, wd_log, rd_log.size());
        end
    endtask

    task automatic test_overflow();
        int unsigned exp_rd[4] = '{32'h3FF, 32'h220, 32'h000, 32'h221};
        logic [31:0] exp_w;
        bit ok;
`ifdef CONV_SEQ_RELU_EN
        exp_w = 32'h0000_0000;
`else
        exp_w = 32'h8000_0000;
`endif
        mem[10'h3FF] = 32'h7FFF_FFFF; mem[10'h000] = 32'd1;
        mem[10'h220] = 32'd0;         mem[10'h221] = 32'd0;
        wr_ready = 1'b1;
        launch(10'h3FF, 10'h220, 10'h000, 10'h3FE, 8'd2, 8'd1);
        wait_done(60, "ovf");
        ok = (rd_log.size() == 4);
        for (int i = 0; i < 4 && ok; i++) ok = (rd_log[i] == exp_rd[i]);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ovf_addr_wrap: got %p required %p", rd_log, exp_rd);
        end
        total++;
        if (acc_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag: got %b required 1", acc_ovf);
        end
        total++;
        if (wd_log.size() != 1 || wd_log[0] !== exp_w) begin
            bad++;
            $display("FAIL ovf_wdata: got %p required %h", wd_log, exp_w);
        end
        launch(10'h100, 10'h200, 10'h000, 10'h300, 8'd2, 8'd1);
        total++;
        if (acc_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear_on_start: got %b required 0", acc_ovf);
        end
        wait_done(60, "ovf_rerun");
        total++;
        if (wd_log.size() != 1 || wd_log[0] !== 32'd30 || acc_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_rerun: data %p ovf=%b required 30 0", wd_log, acc_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        wr_ready = 1'b1;
        launch(10'h130, 10'h230, 10'h000, 10'h330, 8'd3, 8'd1);
        while (mac_cnt < 2 && n < 40) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        total++;
        if ({busy, rd_en, wr_en, done, alu_ctrl} !== 7'b0) begin
            bad++;
            $display("FAIL rstmid_idle: busy=%b rd_en=%b wr_en=%b done=%b ctrl=%b required all 0", busy, rd_en, wr_en, done, alu_ctrl);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        total++;
        if (wr_en_cnt != 0 || done_cnt != 0 || mac_cnt != 2) begin
            bad++;
            $display("FAIL rstmid_abort: wr_cycles=%0d done=%0d macs=%0d required 0 0 2", wr_en_cnt, done_cnt, mac_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
        cfg_ker_base = '0; cfg_img_base = '0; cfg_img_stride = '0; cfg_out_base = '0;
        cfg_taps = '0; cfg_num_out = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        clear_logs();
        test_reset();
        test_basic();
        test_stride();
        test_backpressure();
        test_zero();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
